// File: rtl/adder_tree_loader.sv
// Operand loader and result collector for adder_tree_top: packs eight stream words
// into a stable bank, waits out the tree latency and returns the captured sum.
module adder_tree_loader #(
  parameter int ADDER_WIDTH  = 8,
  parameter int TREE_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDER_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDER_WIDTH-1:0] isum0_0_0_0,
  output logic [ADDER_WIDTH-1:0] isum0_0_0_1,
  output logic [ADDER_WIDTH-1:0] isum0_0_1_0,
  output logic [ADDER_WIDTH-1:0] isum0_0_1_1,
  output logic [ADDER_WIDTH-1:0] isum0_1_0_0,
  output logic [ADDER_WIDTH-1:0] isum0_1_0_1,
  output logic [ADDER_WIDTH-1:0] isum0_1_1_0,
  output logic [ADDER_WIDTH-1:0] isum0_1_1_1,
  input  logic [ADDER_WIDTH:0]   tree_sum,
  output logic [ADDER_WIDTH:0]   out_sum,
  output logic                   out_ovf,
  output logic                   out_mismatch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int AW = ADDER_WIDTH + 3;
  localparam int CW = $clog2(TREE_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDER_WIDTH-1:0] bank_q [8];
  logic [ADDER_WIDTH-1:0] bank_d [8];
  logic [ADDER_WIDTH:0]   out_sum_q, out_sum_d;
  logic                   out_ovf_q, out_ovf_d;
  logic                   out_mismatch_q, out_mismatch_d;
  logic                   out_valid_q, out_valid_d;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    wait_cnt_d     = wait_cnt_q;
    bank_d         = bank_q;
    out_sum_d      = out_sum_q;
    out_ovf_d      = out_ovf_q;
    out_mismatch_d = out_mismatch_q;
    out_valid_d    = out_valid_q;
    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (in_valid) begin
          bank_d[idx_q] = in_data;
          acc_d         = acc_q + AW'(in_data);
          idx_d         = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            wait_cnt_d = CW'(TREE_LATENCY);
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        // The bank has been stable since the last accept, so the tree output is settled here.
        if (wait_cnt_q == '0) begin
          out_sum_d      = tree_sum;
          out_ovf_d      = |acc_q[AW-1:ADDER_WIDTH+1];
          out_mismatch_d = (tree_sum != acc_q[ADDER_WIDTH:0]);
          out_valid_d    = 1'b1;
          state_d        = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          idx_d       = '0;
          acc_d       = '0;
          out_valid_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      wait_cnt_q     <= '0;
      out_sum_q      <= '0;
      out_ovf_q      <= 1'b0;
      out_mismatch_q <= 1'b0;
      out_valid_q    <= 1'b0;
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      wait_cnt_q     <= wait_cnt_d;
      out_sum_q      <= out_sum_d;
      out_ovf_q      <= out_ovf_d;
      out_mismatch_q <= out_mismatch_d;
      out_valid_q    <= out_valid_d;
      for (int i = 0; i < 8; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign in_ready     = (state_q == FILL);
  assign out_sum      = out_sum_q;
  assign out_ovf      = out_ovf_q;
  assign out_mismatch = out_mismatch_q;
  assign out_valid    = out_valid_q;

  assign isum0_0_0_0 = bank_q[0];
  assign isum0_0_0_1 = bank_q[1];
  assign isum0_0_1_0 = bank_q[2];
  assign isum0_0_1_1 = bank_q[3];
  assign isum0_1_0_0 = bank_q[4];
  assign isum0_1_0_1 = bank_q[5];
  assign isum0_1_1_0 = bank_q[6];
  assign isum0_1_1_1 = bank_q[7];

endmodule

// File: tb/tb_adder_tree_loader.sv
// Bench for adder_tree_loader with a two-stage adder tree stub and a result scoreboard.
module tb_adder_tree_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] isum0_0_0_0, isum0_0_0_1, isum0_0_1_0, isum0_0_1_1;
  logic [W-1:0] isum0_1_0_0, isum0_1_0_1, isum0_1_1_0, isum0_1_1_1;
  logic [W:0]   tree_sum;
  logic [W:0]   out_sum;
  logic         out_ovf, out_mismatch, out_valid;
  logic         out_ready = 1'b0;

  logic         force_zero = 1'b0;
  logic [W+2:0] stage1, stage2;

  typedef struct packed {
    logic [W:0] sum;
    logic       ovf;
    logic       mism;
  } result_t;

  result_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_tree_loader #(.ADDER_WIDTH(W), .TREE_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .isum0_0_0_0(isum0_0_0_0), .isum0_0_0_1(isum0_0_0_1),
    .isum0_0_1_0(isum0_0_1_0), .isum0_0_1_1(isum0_0_1_1),
    .isum0_1_0_0(isum0_1_0_0), .isum0_1_0_1(isum0_1_0_1),
    .isum0_1_1_0(isum0_1_1_0), .isum0_1_1_1(isum0_1_1_1),
    .tree_sum(tree_sum), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_mismatch(out_mismatch), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Tree stub: two register stages of the full sum, truncated like the real tree.
  always @(posedge clk) begin
    stage1 <= (W+3)'(isum0_0_0_0) + (W+3)'(isum0_0_0_1) + (W+3)'(isum0_0_1_0)
            + (W+3)'(isum0_0_1_1) + (W+3)'(isum0_1_0_0) + (W+3)'(isum0_1_0_1)
            + (W+3)'(isum0_1_1_0) + (W+3)'(isum0_1_1_1);
    stage2 <= stage1;
  end
  assign tree_sum = force_zero ? '0 : stage2[W:0];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one comparison set per result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_result", 64'(out_sum), 64'hDEAD);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check_output("out_sum", 64'(out_sum), 64'(e.sum));
        check_output("out_ovf", 64'(out_ovf), 64'(e.ovf));
        check_output("out_mismatch", 64'(out_mismatch), 64'(e.mism));
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input int gap);
    int cnt;
    cnt = 0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) check_output("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [W-1:0] w [8], input int gap,
                                input logic [W:0] e_sum, input logic e_ovf, input logic e_mism);
    result_t r;
    r.sum  = e_sum;
    r.ovf  = e_ovf;
    r.mism = e_mism;
    exp_q.push_back(r);
    for (int i = 0; i < 8; i++) send_word(w[i], gap);
  endtask

  // Counts edges after the 8th accept until out_valid is seen high.
  task automatic wait_result(output int edges);
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_in_ready"}, 64'(in_ready), 64'd0);
    check_output({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check_output({name, "_out_flags"}, 64'({out_sum, out_ovf, out_mismatch}), 64'd0);
    check_output({name, "_bank"}, {isum0_0_0_0, isum0_0_0_1, isum0_0_1_0, isum0_0_1_1,
                                   isum0_1_0_0, isum0_1_0_1, isum0_1_1_0, isum0_1_1_1}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [W-1:0] w [8];
    int edges;

    #3 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_output("post_reset_idle", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check_output("post_reset_fill", 64'(in_ready), 64'd1);

    // Frame 1..8 with out_ready held high
    out_ready = 1'b1;
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    apply_stimulus(w, 0, 9'd36, 1'b0, 1'b0);
    check_output("bank_word7", 64'(isum0_1_1_1), 64'd8);
    check_output("bank_word0", 64'(isum0_0_0_0), 64'd1);
    wait_result(edges);
    check_output("latency", 64'(edges), 64'd3);
    @(posedge clk);
    #1 check_output("valid_drop", 64'(out_valid), 64'd0);

    // Overflow frame
    w = '{default: 8'hFF};
    apply_stimulus(w, 0, 9'h1F8, 1'b1, 1'b0);
    wait_result(edges);
    check_output("latency_ff", 64'(edges), 64'd3);

    // Operand mapping
    w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    apply_stimulus(w, 0, 9'd1, 1'b0, 1'b0);
    check_output("map_1_0_1", 64'(isum0_1_0_1), 64'd1);
    check_output("map_others", {isum0_0_0_0, isum0_0_0_1, isum0_0_1_0, isum0_0_1_1,
                                isum0_1_0_0, isum0_1_1_0, isum0_1_1_1}, 64'd0);
    wait_result(edges);
    check_output("latency_map", 64'(edges), 64'd3);

    // Mismatch with the tree forced to zero
    @(posedge clk);
    #1 force_zero = 1'b1;
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    apply_stimulus(w, 0, 9'd0, 1'b0, 1'b1);
    wait_result(edges);
    check_output("latency_mism", 64'(edges), 64'd3);
    @(posedge clk);
    #1 force_zero = 1'b0;

    // Stall: gapped input, result held for 5 cycles, next frame presented early
    out_ready = 1'b0;
    w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    apply_stimulus(w, 2, 9'h168, 1'b0, 1'b0);
    wait_result(edges);
    check_output("latency_stall", 64'(edges), 64'd3);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_output("stall_valid", 64'(out_valid), 64'd1);
      check_output("stall_sum", 64'(out_sum), 64'h168);
      check_output("stall_in_ready", 64'(in_ready), 64'd0);
      check_output("stall_bank0", 64'(isum0_0_0_0), 64'd10);
    end
    out_ready = 1'b1;
    w = '{8'h55, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    begin
      result_t r;
      r.sum = 9'h71; r.ovf = 1'b0; r.mism = 1'b0;
      exp_q.push_back(r);
    end
    edges = 0;
    while (!in_ready && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check_output("second_frame_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_output("second_first_word", 64'(isum0_0_0_0), 64'h55);
    check_output("second_word1_old", 64'(isum0_0_0_1), 64'd20);
    for (int i = 1; i < 8; i++) send_word(w[i], 0);
    wait_result(edges);
    check_output("latency_second", 64'(edges), 64'd3);

    // Reset asserted mid-WAIT discards the frame
    w = '{default: 8'd9};
    for (int i = 0; i < 8; i++) send_word(w[i], 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midwait_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_output("midwait_idle", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check_output("midwait_fill", 64'(in_ready), 64'd1);
    check_output("midwait_no_valid", 64'(out_valid), 64'd0);

    repeat (4) @(posedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
